// File: rtl/fc_tx_credit_gate_if.sv
// Credit-message and TLP-request bundle between the TX buffer / RX credit reporting and the credit gate.
// The master drives messages and requests; the slave (credit gate) answers with req_ready.
interface fc_tx_credit_gate_if #(
    parameter int NUM_VC = 2,
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic              fc_valid;
    logic              fc_init;
    logic [VC_W-1:0]   fc_vc;
    logic [1:0]        fc_type;
    logic [HDR_W-1:0]  fc_hdr;
    logic [DATA_W-1:0] fc_data;

    logic              req_valid;
    logic [VC_W-1:0]   req_vc;
    logic [1:0]        req_type;
    logic [DATA_W-1:0] req_data_cr;
    logic              req_ready;

    modport master (
        output fc_valid, fc_init, fc_vc, fc_type, fc_hdr, fc_data,
        output req_valid, req_vc, req_type, req_data_cr,
        input  req_ready
    );

    modport slave (
        input  fc_valid, fc_init, fc_vc, fc_type, fc_hdr, fc_data,
        input  req_valid, req_vc, req_type, req_data_cr,
        output req_ready
    );
endinterface

// File: rtl/fc_tx_credit_gate.sv
// TX flow-control credit gate: per-VC/class credit limits and consumption, infinite-credit aware.
// req_ready is combinational from registered state (0-cycle); requests are held, never queued.
module fc_tx_credit_gate #(
    parameter int NUM_VC = 2,
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               link_up,
    fc_tx_credit_gate_if.slave bus,
    output logic [NUM_VC-1:0]  vc_active,
    output logic               fc_err
);
    localparam int                VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [VC_W:0]     NUM_VC_L   = (VC_W + 1)'(NUM_VC);
    localparam logic [HDR_W-1:0]  HDR_HALF   = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [1:0]        TY_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {ST_UNINIT, ST_INIT, ST_ACTIVE} vc_state_e;

    vc_state_e         state_q     [NUM_VC];
    logic [2:0]        init_seen_q [NUM_VC];
    logic [HDR_W-1:0]  cl_hdr_q    [NUM_VC][3];
    logic [HDR_W-1:0]  cc_hdr_q    [NUM_VC][3];
    logic [DATA_W-1:0] cl_data_q   [NUM_VC][3];
    logic [DATA_W-1:0] cc_data_q   [NUM_VC][3];
    logic              inf_hdr_q   [NUM_VC][3];
    logic              inf_data_q  [NUM_VC][3];
    logic              fc_err_q;
    logic              fc_err_d;

    logic              req_vc_ok, req_ty_ok;
    logic [VC_W-1:0]   req_sel_vc;
    logic [1:0]        req_sel_ty;
    logic [HDR_W-1:0]  hdr_left;
    logic [DATA_W-1:0] data_left;
    logic              hdr_ok, data_ok, accept;

    logic              fc_vc_ok, fc_ty_ok, fc_ok;
    logic [VC_W-1:0]   fc_sel_vc;
    logic [1:0]        fc_sel_ty;
    logic              fc_vc_is_active, init_wr, upd_wr, init_done;

    // Out-of-range selectors are steered to entry 0 so array reads stay in bounds; the ok flags veto them.
    always_comb begin
        req_vc_ok  = ({1'b0, bus.req_vc} < NUM_VC_L);
        req_ty_ok  = (bus.req_type != TY_ILLEGAL);
        req_sel_vc = req_vc_ok ? bus.req_vc : '0;
        req_sel_ty = req_ty_ok ? bus.req_type : 2'd0;

        hdr_left  = cl_hdr_q[req_sel_vc][req_sel_ty] - cc_hdr_q[req_sel_vc][req_sel_ty] - HDR_W'(1);
        data_left = cl_data_q[req_sel_vc][req_sel_ty] - cc_data_q[req_sel_vc][req_sel_ty]
                    - bus.req_data_cr;
        hdr_ok    = inf_hdr_q[req_sel_vc][req_sel_ty] || (hdr_left <= HDR_HALF);
        data_ok   = (bus.req_data_cr == '0) || inf_data_q[req_sel_vc][req_sel_ty]
                    || (data_left <= DATA_HALF);

        accept = bus.req_valid && link_up && req_vc_ok && req_ty_ok
                 && (state_q[req_sel_vc] == ST_ACTIVE) && hdr_ok && data_ok;
    end

    always_comb begin
        fc_vc_ok        = ({1'b0, bus.fc_vc} < NUM_VC_L);
        fc_ty_ok        = (bus.fc_type != TY_ILLEGAL);
        fc_ok           = fc_vc_ok && fc_ty_ok;
        fc_sel_vc       = fc_vc_ok ? bus.fc_vc : '0;
        fc_sel_ty       = fc_ty_ok ? bus.fc_type : 2'd0;
        fc_vc_is_active = (state_q[fc_sel_vc] == ST_ACTIVE);

        init_wr   = link_up && bus.fc_valid && fc_ok && bus.fc_init && !fc_vc_is_active;
        upd_wr    = link_up && bus.fc_valid && fc_ok && !bus.fc_init && fc_vc_is_active;
        init_done = &(init_seen_q[fc_sel_vc] | (3'b001 << fc_sel_ty));

        fc_err_d = link_up && ((bus.fc_valid && !fc_ok)
                               || (bus.fc_valid && fc_ok && !bus.fc_init && !fc_vc_is_active)
                               || (bus.req_valid && !req_vc_ok));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !link_up) begin
            fc_err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v]     <= ST_UNINIT;
                init_seen_q[v] <= '0;
                for (int c = 0; c < 3; c++) begin
                    cl_hdr_q[v][c]   <= '0;
                    cc_hdr_q[v][c]   <= '0;
                    cl_data_q[v][c]  <= '0;
                    cc_data_q[v][c]  <= '0;
                    inf_hdr_q[v][c]  <= 1'b0;
                    inf_data_q[v][c] <= 1'b0;
                end
            end
        end else begin
            fc_err_q <= fc_err_d;

            if (accept) begin
                if (!inf_hdr_q[req_sel_vc][req_sel_ty])
                    cc_hdr_q[req_sel_vc][req_sel_ty] <= cc_hdr_q[req_sel_vc][req_sel_ty] + HDR_W'(1);
                if (!inf_data_q[req_sel_vc][req_sel_ty])
                    cc_data_q[req_sel_vc][req_sel_ty] <= cc_data_q[req_sel_vc][req_sel_ty]
                                                         + bus.req_data_cr;
            end

            // A zero InitFC value advertises infinite credit for that field.
            if (init_wr) begin
                cl_hdr_q[fc_sel_vc][fc_sel_ty]   <= bus.fc_hdr;
                cl_data_q[fc_sel_vc][fc_sel_ty]  <= bus.fc_data;
                inf_hdr_q[fc_sel_vc][fc_sel_ty]  <= (bus.fc_hdr == '0);
                inf_data_q[fc_sel_vc][fc_sel_ty] <= (bus.fc_data == '0);
                init_seen_q[fc_sel_vc][fc_sel_ty] <= 1'b1;
                state_q[fc_sel_vc] <= init_done ? ST_ACTIVE : ST_INIT;
            end

            if (upd_wr) begin
                if (!inf_hdr_q[fc_sel_vc][fc_sel_ty])
                    cl_hdr_q[fc_sel_vc][fc_sel_ty] <= bus.fc_hdr;
                if (!inf_data_q[fc_sel_vc][fc_sel_ty])
                    cl_data_q[fc_sel_vc][fc_sel_ty] <= bus.fc_data;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) vc_active[v] = (state_q[v] == ST_ACTIVE);
    end

    assign fc_err        = fc_err_q;
    assign bus.req_ready = accept;
endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// Bench for fc_tx_credit_gate: directed vector table, hand sequences for wrap/infinite/link-down,
// then randomized traffic against a credit-accounting reference model.
module tb_fc_tx_credit_gate;
    localparam int NUM_VC = 2;
    localparam int HDR_W  = 8;
    localparam int DATA_W = 12;
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int HMOD   = 1 << HDR_W;
    localparam int DMOD   = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              link_up;
    logic [NUM_VC-1:0] vc_active;
    logic              fc_err;

    fc_tx_credit_gate_if #(.NUM_VC(NUM_VC), .HDR_W(HDR_W), .DATA_W(DATA_W)) bus ();

    fc_tx_credit_gate #(.NUM_VC(NUM_VC), .HDR_W(HDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .link_up   (link_up),
        .bus       (bus),
        .vc_active (vc_active),
        .fc_err    (fc_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic              s_rdy;
    logic [NUM_VC-1:0] s_act;
    logic              s_err;

    // Reference model: credit limits/consumption as plain integers; a VC is active once all classes saw InitFC.
    int m_lim_h  [NUM_VC][3];
    int m_used_h [NUM_VC][3];
    int m_lim_d  [NUM_VC][3];
    int m_used_d [NUM_VC][3];
    bit m_inf_h  [NUM_VC][3];
    bit m_inf_d  [NUM_VC][3];
    bit m_seen   [NUM_VC][3];
    bit m_err;

    function automatic void m_clear();
        for (int v = 0; v < NUM_VC; v++)
            for (int c = 0; c < 3; c++) begin
                m_lim_h[v][c] = 0; m_used_h[v][c] = 0;
                m_lim_d[v][c] = 0; m_used_d[v][c] = 0;
                m_inf_h[v][c] = 0; m_inf_d[v][c]  = 0;
                m_seen[v][c]  = 0;
            end
        m_err = 0;
    endfunction

    function automatic bit m_is_active(int v);
        return m_seen[v][0] && m_seen[v][1] && m_seen[v][2];
    endfunction

    function automatic logic [NUM_VC-1:0] m_act_vec();
        logic [NUM_VC-1:0] a;
        for (int v = 0; v < NUM_VC; v++) a[v] = m_is_active(v);
        return a;
    endfunction

    function automatic bit fits(int lim, int used, int need, int modulus);
        return ((lim - used - need) & (modulus - 1)) <= modulus / 2;
    endfunction

    function automatic bit m_ready();
        int v, t, need;
        v    = int'(bus.req_vc);
        t    = int'(bus.req_type);
        need = int'(bus.req_data_cr);
        if (!bus.req_valid || !link_up || t == 3 || v >= NUM_VC) return 1'b0;
        if (!m_is_active(v)) return 1'b0;
        if (!m_inf_h[v][t] && !fits(m_lim_h[v][t], m_used_h[v][t], 1, HMOD)) return 1'b0;
        if (need != 0 && !m_inf_d[v][t] && !fits(m_lim_d[v][t], m_used_d[v][t], need, DMOD))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_step(bit acc);
        int v, t;
        bit e;
        if (!rst_n || !link_up) begin
            m_clear();
            return;
        end
        e = 0;
        if (bus.fc_valid) begin
            v = int'(bus.fc_vc);
            t = int'(bus.fc_type);
            if (t == 3 || v >= NUM_VC) e = 1;
            else if (bus.fc_init) begin
                if (!m_is_active(v)) begin
                    m_lim_h[v][t] = int'(bus.fc_hdr);
                    m_lim_d[v][t] = int'(bus.fc_data);
                    m_inf_h[v][t] = (bus.fc_hdr == 0);
                    m_inf_d[v][t] = (bus.fc_data == 0);
                    m_seen[v][t]  = 1;
                end
            end else if (!m_is_active(v)) e = 1;
            else begin
                if (!m_inf_h[v][t]) m_lim_h[v][t] = int'(bus.fc_hdr);
                if (!m_inf_d[v][t]) m_lim_d[v][t] = int'(bus.fc_data);
            end
        end
        if (bus.req_valid && int'(bus.req_vc) >= NUM_VC) e = 1;
        if (acc) begin
            v = int'(bus.req_vc);
            t = int'(bus.req_type);
            if (!m_inf_h[v][t]) m_used_h[v][t] = (m_used_h[v][t] + 1) % HMOD;
            if (!m_inf_d[v][t]) m_used_d[v][t] = (m_used_d[v][t] + int'(bus.req_data_cr)) % DMOD;
        end
        m_err = e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic set_in(input int link, input int fv, input int fi, input int fvc, input int fty,
                          input int fh, input int fd, input int rv, input int rvc, input int rty,
                          input int rcr);
        link_up         = (link != 0);
        bus.fc_valid    = (fv != 0);
        bus.fc_init     = (fi != 0);
        bus.fc_vc       = VC_W'(fvc);
        bus.fc_type     = 2'(fty);
        bus.fc_hdr      = HDR_W'(fh);
        bus.fc_data     = DATA_W'(fd);
        bus.req_valid   = (rv != 0);
        bus.req_vc      = VC_W'(rvc);
        bus.req_type    = 2'(rty);
        bus.req_data_cr = DATA_W'(rcr);
    endtask

    // Samples at the falling edge, checks against the model, then advances the model over the rising edge.
    task automatic cycle();
        bit r;
        @(negedge clk);
        r     = m_ready();
        s_rdy = bus.req_ready;
        s_act = vc_active;
        s_err = fc_err;
        chk("model_req_ready", 32'(s_rdy), 32'(r));
        chk("model_vc_active", 32'(s_act), 32'(m_act_vec()));
        chk("model_fc_err",    32'(s_err), 32'(m_err));
        m_step(r);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int link, fv, fi, fvc, fty, fh, fd;
        int rv, rvc, rty, rcr;
        int e_rdy, e_act, e_err;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int fv, fi, fvc, fty, fh, fd, rv, rvc, rty, rcr, lk;

        //         link fv fi vc ty  h   d   rv vc ty cr  rdy act err
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 4,  16, 1, 0, 0, 4,  0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 1, 1,  0,  1, 0, 0, 4,  0, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 2, 0,  0,  1, 0, 0, 4,  0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  1, 1, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  1, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  1, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  1, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  0, 1, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  0, 1, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 5,  20, 1, 0, 0, 4,  0, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  1, 1, 0};
        tbl[12] = '{1, 1, 0, 1, 0, 3,  3,  0, 0, 0, 0,  0, 1, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 1, 1};
        tbl[14] = '{1, 1, 0, 0, 3, 1,  1,  0, 0, 0, 0,  0, 1, 0};
        tbl[15] = '{1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 1, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 1, 0};
        tbl[17] = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 2, 64, 1, 1, 0};
        tbl[18] = '{1, 1, 1, 0, 0, 9,  9,  0, 0, 0, 0,  0, 1, 0};
        tbl[19] = '{1, 0, 0, 0, 0, 0,  0,  1, 0, 0, 4,  0, 1, 0};

        rst_n = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        m_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vc_active", 32'(vc_active), 32'd0);
        chk("rst_fc_err",    32'(fc_err),    32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].link, tbl[i].fv, tbl[i].fi, tbl[i].fvc, tbl[i].fty, tbl[i].fh, tbl[i].fd,
                   tbl[i].rv, tbl[i].rvc, tbl[i].rty, tbl[i].rcr);
            cycle();
            chk($sformatf("vec%0d_req_ready", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_vc_active", i), 32'(s_act), 32'(tbl[i].e_act));
            chk($sformatf("vec%0d_fc_err", i),    32'(s_err), 32'(tbl[i].e_err));
        end

        // Infinite Cpl credit: every request accepted, UpdateFC ignored.
        acc = 0;
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 64);
        repeat (1000) begin
            cycle();
            if (s_rdy) acc++;
        end
        chk("cpl_inf_accepts", 32'(acc), 32'd1000);
        set_in(1, 1, 0, 0, 2, 5, 5, 0, 0, 0, 0);
        cycle();
        acc = 0;
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 64);
        repeat (10) begin
            cycle();
            if (s_rdy) acc++;
        end
        chk("cpl_after_update_accepts", 32'(acc), 32'd10);

        // Header counter wrap: P limit tracks one ahead of consumption until CC_hdr reaches 255.
        set_in(1, 1, 0, 0, 0, 6, 20, 0, 0, 0, 0);
        cycle();
        acc = 0;
        for (int k = 5; k < 255; k++) begin
            set_in(1, 1, 0, 0, 0, (k + 2) % 256, 20, 1, 0, 0, 0);
            cycle();
            if (s_rdy) acc++;
        end
        chk("wrap_fill_accepts", 32'(acc), 32'd250);
        set_in(1, 1, 0, 0, 0, 3, 20, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
        chk("wrap_accept", 32'(s_rdy), 32'd1);
        acc = 0;
        repeat (5) begin
            cycle();
            if (s_rdy) acc++;
        end
        chk("post_wrap_accepts", 32'(acc), 32'd3);
        chk("post_wrap_blocked", 32'(s_rdy), 32'd0);

        // Link drop mid-stream clears everything; re-init required.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 64);
        cycle();
        chk("pre_linkdown_ready", 32'(s_rdy), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 64);
        cycle();
        chk("linkdown_ready", 32'(s_rdy), 32'd0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("linkdown_vc_active", 32'(s_act), 32'd0);
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 64);
        cycle();
        chk("reinit_needed_ready", 32'(s_rdy), 32'd0);
        set_in(1, 1, 1, 0, 0, 1, 8, 0, 0, 0, 0);
        cycle();
        set_in(1, 1, 1, 0, 1, 2, 2, 0, 0, 0, 0);
        cycle();
        set_in(1, 1, 1, 0, 2, 4, 4, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8);
        cycle();
        chk("reinit_first_ready", 32'(s_rdy), 32'd1);
        cycle();
        chk("reinit_cc_cleared_block", 32'(s_rdy), 32'd0);

        // Randomized traffic with occasional link drops and resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) begin
                rst_n = 1'b0;
                set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                cycle();
                rst_n = 1'b1;
            end else begin
                lk  = ($urandom_range(0, 149) != 0) ? 1 : 0;
                fv  = int'($urandom_range(0, 1));
                fi  = ($urandom_range(0, 2) == 0) ? 1 : 0;
                fvc = int'($urandom_range(0, NUM_VC - 1));
                fty = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                fh  = int'($urandom_range(0, 6));
                fd  = int'($urandom_range(0, 40));
                rv  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                rvc = int'($urandom_range(0, NUM_VC - 1));
                rty = int'($urandom_range(0, 2));
                rcr = int'($urandom_range(0, 12));
                set_in(lk, fv, fi, fvc, fty, fh, fd, rv, rvc, rty, rcr);
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
